// File: rtl/regfile_debug_dumper.sv
// Register file debug dumper: walks every register on the display read port
// and sends one "A:DDDD\r\n" line per register over a UART 8N1 transmitter.
module regfile_debug_dumper #(
    parameter int unsigned p_data_width    = 16,
    parameter int unsigned p_address_width = 3,
    parameter int unsigned p_clks_per_bit  = 868
) (
    input  logic                       i_w_clk,
    input  logic                       i_w_rst_n,
    input  logic                       i_w_start,
    output logic [p_address_width-1:0] o_w_disp_address,
    input  logic [p_data_width-1:0]    i_w_disp_data,
    output logic                       o_w_tx,
    output logic                       o_w_busy,
    output logic                       o_w_done
);

    // Hex digits per value, padded snapshot width, characters per line
    localparam int unsigned c_digits     = (p_data_width + 3) / 4;
    localparam int unsigned c_pad_width  = 4 * c_digits;
    localparam int unsigned c_chars      = c_digits + 4;
    localparam int unsigned c_clk_width  = $clog2(p_clks_per_bit);
    localparam int unsigned c_char_width = $clog2(c_chars);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_CAPTURE,
        S_SEND,
        S_FIN
    } state_t;

    state_t                     state_q, state_d;
    logic                       tx_q, tx_d;
    logic                       busy_q, busy_d;
    logic                       done_q, done_d;
    logic [p_address_width-1:0] addr_q, addr_d;
    logic [c_pad_width-1:0]     shift_q, shift_d;
    logic [c_clk_width-1:0]     clk_cnt_q, clk_cnt_d;
    logic [3:0]                 bit_idx_q, bit_idx_d;
    logic [c_char_width-1:0]    char_idx_q, char_idx_d;

    logic [1:0]                 rst_sync;
    logic                       rst_n_int;
    logic                       is_data_char_c;
    logic [7:0]                 cur_char_c;
    logic [9:0]                 frame_c;

    // Nibble to uppercase ASCII hex digit
    function automatic logic [7:0] hex_ascii(input logic [3:0] nibble);
        if (nibble < 4'd10) begin
            return 8'h30 + {4'h0, nibble};
        end
        return 8'h37 + {4'h0, nibble};
    endfunction

    // Reset synchronizer: asserts immediately, releases two clocks later
    always_ff @(posedge i_w_clk or negedge i_w_rst_n) begin
        if (!i_w_rst_n) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_n_int = rst_sync[1];

    // Character currently on the line, selected by position within the line
    always_comb begin
        is_data_char_c = (char_idx_q >= c_char_width'(2)) &&
                         (char_idx_q <= c_char_width'(c_digits + 1));
        if (char_idx_q == c_char_width'(0)) begin
            cur_char_c = hex_ascii(4'(addr_q));
        end else if (char_idx_q == c_char_width'(1)) begin
            cur_char_c = 8'h3A;
        end else if (is_data_char_c) begin
            cur_char_c = hex_ascii(shift_q[c_pad_width-1 -: 4]);
        end else if (char_idx_q == c_char_width'(c_digits + 2)) begin
            cur_char_c = 8'h0D;
        end else begin
            cur_char_c = 8'h0A;
        end
        frame_c = {1'b1, cur_char_c, 1'b0};
    end

    // State and registered outputs
    always_ff @(posedge i_w_clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            state_q    <= S_IDLE;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            addr_q     <= '0;
            shift_q    <= '0;
            clk_cnt_q  <= '0;
            bit_idx_q  <= '0;
            char_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            addr_q     <= addr_d;
            shift_q    <= shift_d;
            clk_cnt_q  <= clk_cnt_d;
            bit_idx_q  <= bit_idx_d;
            char_idx_q <= char_idx_d;
        end
    end

    // Next state and next output values
    always_comb begin
        state_d    = state_q;
        tx_d       = tx_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        addr_d     = addr_q;
        shift_d    = shift_q;
        clk_cnt_d  = clk_cnt_q;
        bit_idx_d  = bit_idx_q;
        char_idx_d = char_idx_q;

        case (state_q)
            S_IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (i_w_start) begin
                    state_d = S_ADDR;
                    busy_d  = 1'b1;
                    addr_d  = '0;
                end
            end

            S_ADDR: begin
                state_d = S_CAPTURE;
            end

            S_CAPTURE: begin
                shift_d    = c_pad_width'(i_w_disp_data);
                char_idx_d = '0;
                bit_idx_d  = '0;
                clk_cnt_d  = '0;
                tx_d       = 1'b0;
                state_d    = S_SEND;
            end

            S_SEND: begin
                if (clk_cnt_q == c_clk_width'(p_clks_per_bit - 1)) begin
                    clk_cnt_d = '0;
                    if (bit_idx_q == 4'd9) begin
                        // Stop bit finished: next char, next register, or end
                        if (is_data_char_c) begin
                            shift_d = shift_q << 4;
                        end
                        if (char_idx_q != c_char_width'(c_chars - 1)) begin
                            char_idx_d = char_idx_q + c_char_width'(1);
                            bit_idx_d  = '0;
                            tx_d       = 1'b0;
                        end else if (addr_q != {p_address_width{1'b1}}) begin
                            addr_d  = addr_q + p_address_width'(1);
                            tx_d    = 1'b1;
                            state_d = S_ADDR;
                        end else begin
                            tx_d    = 1'b1;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                            state_d = S_FIN;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + 4'd1;
                        tx_d      = frame_c[bit_idx_q + 4'd1];
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + c_clk_width'(1);
                end
            end

            S_FIN: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign o_w_disp_address = addr_q;
    assign o_w_tx           = tx_q;
    assign o_w_busy         = busy_q;
    assign o_w_done         = done_q;

endmodule

// File: tb/tb_regfile_debug_dumper.sv
// Directed bench for regfile_debug_dumper with a register file model,
// a UART receiver and an expected-character scoreboard.
module tb_regfile_debug_dumper;

    localparam int CPB      = 4;
    localparam int DIG      = 4;
    localparam int NREG     = 8;
    localparam int BUSY_CYC = NREG * (2 + 10 * CPB * (DIG + 4));
    localparam int LIMIT    = BUSY_CYC + 200;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  addr;
    logic [15:0] disp_data;
    logic        tx;
    logic        busy;
    logic        done;

    logic [15:0] regs [NREG];
    logic [7:0]  sb [$];

    int checks = 0;
    int errors = 0;

    regfile_debug_dumper #(
        .p_data_width   (16),
        .p_address_width(3),
        .p_clks_per_bit (CPB)
    ) dut (
        .i_w_clk         (clk),
        .i_w_rst_n       (rst_n),
        .i_w_start       (start),
        .o_w_disp_address(addr),
        .i_w_disp_data   (disp_data),
        .o_w_tx          (tx),
        .o_w_busy        (busy),
        .o_w_done        (done)
    );

    assign disp_data = regs[addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] hexc(input logic [3:0] n);
        logic [7:0] digits [16];
        digits = '{"0", "1", "2", "3", "4", "5", "6", "7",
                   "8", "9", "A", "B", "C", "D", "E", "F"};
        return digits[n];
    endfunction

    // Expected characters of one whole dump, from the current register contents
    task automatic push_dump();
        for (int a = 0; a < NREG; a++) begin
            sb.push_back(hexc(4'(a)));
            sb.push_back(8'h3A);
            for (int d = DIG - 1; d >= 0; d--) begin
                sb.push_back(hexc(regs[a][4*d +: 4]));
            end
            sb.push_back(8'h0D);
            sb.push_back(8'h0A);
        end
    endtask

    // UART receiver: finds the start bit, samples mid-bit, compares with the scoreboard
    initial begin
        logic [7:0] rx_ch;
        logic       rx_start_v;
        logic       rx_stop_v;
        bit         rx_abort;
        int         rx_count;
        rx_count = 0;
        forever begin
            @(negedge clk);
            if (rst_n && tx === 1'b0) begin
                rx_abort   = 1'b0;
                rx_ch      = '0;
                rx_start_v = 1'b1;
                rx_stop_v  = 1'b0;
                for (int off = 1; off < 10 * CPB; off++) begin
                    @(negedge clk);
                    if (!rst_n) rx_abort = 1'b1;
                    if (off % CPB == CPB / 2) begin
                        if (off / CPB == 0) rx_start_v = tx;
                        else if (off / CPB == 9) rx_stop_v = tx;
                        else rx_ch[off / CPB - 1] = tx;
                    end
                end
                if (!rx_abort) begin
                    if (sb.size() == 0) begin
                        check($sformatf("rx_unexpected_char_%0d", rx_count), 32'(rx_ch), 32'hFFFF_FFFF);
                    end else begin
                        check($sformatf("rx_char_%0d", rx_count), 32'(rx_ch), 32'(sb.pop_front()));
                        check($sformatf("rx_start_%0d", rx_count), 32'(rx_start_v), 32'd0);
                        check($sformatf("rx_stop_%0d", rx_count), 32'(rx_stop_v), 32'd1);
                    end
                    rx_count++;
                end
            end
        end
    end

    // Follows one dump from its N+1 cycle (c=1) to the done pulse
    task automatic track_dump(input int write_at, input int waddr, input logic [15:0] wdata,
                              input bit timing, input int hold_lo, input int hold_hi);
        int c;
        int busy_cnt;
        bit got;
        logic [9:0] frame0;
        frame0   = {1'b1, 8'h30, 1'b0};
        c        = 1;
        busy_cnt = 0;
        got      = 1'b0;
        check("busy_at_n1", 32'(busy), 32'd1);
        check("addr_at_n1", 32'(addr), 32'd0);
        check("tx_at_n1", 32'(tx), 32'd1);
        while (c <= LIMIT) begin
            start = (c >= hold_lo) && (c < hold_hi);
            if (c == write_at) begin
                check("addr_at_write", 32'(addr), 32'(waddr));
                regs[waddr] = wdata;
            end
            if (timing) begin
                if (c == 2) check("tx_capture", 32'(tx), 32'd1);
                if (c >= 3 && c <= 2 + 10 * CPB)
                    check($sformatf("tx_bit_c%0d", c), 32'(tx), 32'(frame0[(c - 3) / CPB]));
                if (c == 3 + 10 * CPB) check("tx_next_start", 32'(tx), 32'd0);
            end
            if (busy) busy_cnt++;
            if (done) begin
                got = 1'b1;
                break;
            end
            @(posedge clk); #1;
            c++;
        end
        check("done_seen", 32'(got), 32'd1);
        check("done_cycle", 32'(c), 32'(BUSY_CYC + 1));
        check("busy_cycles", 32'(busy_cnt), 32'(BUSY_CYC));
        check("busy_at_done", 32'(busy), 32'd0);
    endtask

    task automatic run_dump(input int write_at, input int waddr, input logic [15:0] wdata,
                            input bit timing, input int hold_lo, input int hold_hi);
        push_dump();
        start = 1'b1;
        @(posedge clk); #1;
        track_dump(write_at, waddr, wdata, timing, hold_lo, hold_hi);
    endtask

    // After a dump: no further done pulse, idle line, address held, all chars received
    task automatic quiet_check();
        int extra;
        extra = 0;
        start = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done) extra++;
        end
        check("no_extra_done", 32'(extra), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_tx", 32'(tx), 32'd1);
        check("addr_hold", 32'(addr), 32'd7);
        check("sb_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int dones;
        rst_n = 1'b0;
        start = 1'b0;
        for (int i = 0; i < NREG; i++) regs[i] = 16'(16'h1111 * i);

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_addr", 32'(addr), 32'd0);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        // Basic dump with first-character bit timing
        run_dump(-1, 0, 16'h0, 1'b1, 0, 0);
        quiet_check();

        // Mixed digits including A-F
        regs[3] = 16'hABCD;
        regs[6] = 16'h0F5E;
        run_dump(-1, 0, 16'h0, 1'b0, 0, 0);
        quiet_check();

        // Start held high mid-dump is ignored
        run_dump(-1, 0, 16'h0, 1'b0, 300, 400);
        quiet_check();

        // Write to reg 4 the cycle after its capture: old value on this line
        run_dump(2 + 4 * 322 + 1, 4, 16'h4BEE, 1'b0, 0, 0);
        quiet_check();
        run_dump(-1, 0, 16'h0, 1'b0, 0, 0);
        quiet_check();

        // Start held through the whole dump re-triggers after FIN
        run_dump(-1, 0, 16'h0, 1'b0, 0, 1 << 30);
        @(posedge clk); #1;
        check("retrig_idle_busy", 32'(busy), 32'd0);
        push_dump();
        @(posedge clk); #1;
        track_dump(-1, 0, 16'h0, 1'b0, 0, 0);
        quiet_check();

        // Reset during the data digits of reg 2
        push_dump();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (744) @(posedge clk);
        #1;
        check("pre_rst_addr", 32'(addr), 32'd2);
        rst_n = 1'b0;
        #1;
        check("midrst_tx", 32'(tx), 32'd1);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_addr", 32'(addr), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        sb.delete();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        dones = 0;
        repeat (60) begin
            @(posedge clk); #1;
            if (done || busy) dones++;
        end
        check("post_rst_quiet", 32'(dones), 32'd0);

        // Fresh dump from "0:"
        run_dump(-1, 0, 16'h0, 1'b0, 0, 0);
        quiet_check();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
